// File: rtl/shot_clock_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shot_clock_pkg
//  Description : Shared types and constants for the shot-clock display path.
//  Revision    : 1.0 - initial release
// ============================================================================
package shot_clock_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLASH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  // Number of clock cycles the display stays in one blink phase.
  function automatic int half_period(input int clk_hz, input int flash_hz);
    return clk_hz / (2 * flash_hz);
  endfunction

endpackage
`default_nettype wire

// File: rtl/shot_clock_display_seg7.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decoder
//  Description : 4-bit digit to active-low 7-segment (gfedcba); codes above 9
//                produce a blank digit.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_decoder
  import shot_clock_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  // Pure lookup of the segment pattern for one decimal digit.
  always_comb begin
    seg_o = SEG_BLANK;
    case (digit_i)
      4'd0:    seg_o = 7'b1000000;
      4'd1:    seg_o = 7'b1111001;
      4'd2:    seg_o = 7'b0100100;
      4'd3:    seg_o = 7'b0110000;
      4'd4:    seg_o = 7'b0011001;
      4'd5:    seg_o = 7'b0010010;
      4'd6:    seg_o = 7'b0000010;
      4'd7:    seg_o = 7'b1111000;
      4'd8:    seg_o = 7'b0000000;
      4'd9:    seg_o = 7'b0010000;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/shot_clock_display.sv
`default_nettype none
// ============================================================================
//  Module      : shot_clock_display
//  Description : Two-digit 7-segment driver for the shot-clock count with
//                leading-zero blanking, expiry detection, blinking "00" with
//                buzzer, then a steady expired indication.
//  Revision    : 1.0 - initial release
// ============================================================================
module shot_clock_display
  import shot_clock_pkg::*;
#(
  parameter int CLK_HZ        = 50_000_000,
  parameter int FLASH_HZ      = 2,
  parameter int FLASH_TOGGLES = 6,
  parameter int WIDTH         = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count,
  output logic [6:0]       hex1,
  output logic [6:0]       hex0,
  output logic             buzzer,
  output logic             expired
);

  localparam int HALF = half_period(CLK_HZ, FLASH_HZ);
  localparam int TW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int GW   = (FLASH_TOGGLES > 0) ? $clog2(FLASH_TOGGLES + 1) : 1;

  localparam logic [WIDTH-1:0] C_TEN      = WIDTH'(10);
  localparam logic [TW-1:0]    C_TIM_LAST = TW'(HALF - 1);
  localparam logic [GW-1:0]    C_TOG_LAST = GW'(FLASH_TOGGLES - 1);

  logic [WIDTH-1:0] count_q;
  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [GW-1:0]    tog_q, tog_d;
  logic             blank_q, blank_d;   // 1 = OFF phase of the blink

  logic [3:0]       tens_w, units_w;
  logic [6:0]       seg_tens_w, seg_units_w;
  logic [6:0]       hex1_d, hex0_d;
  logic             buzzer_d, expired_d;

  // Constant-divisor split; count never exceeds 31 so tens fits in 4 bits.
  assign tens_w  = 4'(count_q / C_TEN);
  assign units_w = 4'(count_q % C_TEN);

  seg7_decoder u_seg_tens  (.digit_i(tens_w),  .seg_o(seg_tens_w));
  seg7_decoder u_seg_units (.digit_i(units_w), .seg_o(seg_units_w));

  // Next-state logic; a nonzero count always forces RUN and wins over blink events.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    tog_d   = tog_q;
    blank_d = blank_q;
    case (state_q)
      IDLE: begin
        if (count_q != '0) state_d = RUN;
      end
      RUN: begin
        if (count_q == '0) begin
          state_d = FLASH;
          timer_d = '0;
          tog_d   = '0;
          blank_d = 1'b0;
        end
      end
      FLASH: begin
        if (timer_q == C_TIM_LAST) begin
          timer_d = '0;
          blank_d = ~blank_q;
          tog_d   = tog_q + 1'b1;
          if (tog_q == C_TOG_LAST) state_d = DONE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    if (count_q != '0) begin
      state_d = RUN;
      timer_d = '0;
      tog_d   = '0;
      blank_d = 1'b0;
    end
  end

  // Output decode from the next state so displayed values line up with the FSM.
  always_comb begin
    hex1_d    = (count_q < C_TEN) ? SEG_BLANK : seg_tens_w;
    hex0_d    = seg_units_w;
    buzzer_d  = 1'b0;
    expired_d = 1'b0;
    case (state_d)
      FLASH: begin
        buzzer_d = 1'b1;
        hex1_d   = blank_d ? SEG_BLANK : SEG_ZERO;
        hex0_d   = blank_d ? SEG_BLANK : SEG_ZERO;
      end
      DONE: begin
        expired_d = 1'b1;
        hex1_d    = SEG_ZERO;
        hex0_d    = SEG_ZERO;
      end
      default: ;
    endcase
  end

  // Count capture, FSM state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      state_q <= IDLE;
      timer_q <= '0;
      tog_q   <= '0;
      blank_q <= 1'b0;
      hex1    <= SEG_BLANK;
      hex0    <= SEG_BLANK;
      buzzer  <= 1'b0;
      expired <= 1'b0;
    end else begin
      count_q <= count;
      state_q <= state_d;
      timer_q <= timer_d;
      tog_q   <= tog_d;
      blank_q <= blank_d;
      hex1    <= hex1_d;
      hex0    <= hex0_d;
      buzzer  <= buzzer_d;
      expired <= expired_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shot_clock_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shot_clock_display
//  Description : Directed self-checking bench for shot_clock_display
//                (CLK_HZ=8, FLASH_HZ=2 -> 2-cycle half period, 4 toggles).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shot_clock_display;

  localparam logic [6:0] BLK = 7'b1111111;
  localparam logic [6:0] S0  = 7'b1000000;
  localparam logic [6:0] S1  = 7'b1111001;
  localparam logic [6:0] S2  = 7'b0100100;
  localparam logic [6:0] S3  = 7'b0110000;
  localparam logic [6:0] S4  = 7'b0011001;
  localparam logic [6:0] S7  = 7'b1111000;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] count;
  logic [6:0] hex1, hex0;
  logic       buzzer, expired;

  int checks = 0;
  int errors = 0;

  shot_clock_display #(
    .CLK_HZ(8), .FLASH_HZ(2), .FLASH_TOGGLES(4), .WIDTH(5)
  ) dut (
    .clk(clk), .reset(reset), .count(count),
    .hex1(hex1), .hex0(hex0), .buzzer(buzzer), .expired(expired)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    count = 5'd0;
    #2;
    checks++; if (hex1 !== BLK) begin errors++; $display("FAIL reset_hex1 got %b exp %b", hex1, BLK); end
    checks++; if (hex0 !== BLK) begin errors++; $display("FAIL reset_hex0 got %b exp %b", hex0, BLK); end
    checks++; if (buzzer !== 1'b0 || expired !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b exp 00", buzzer, expired); end
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_digits();
    count = 5'd24; tick(); tick();
    checks++; if (hex1 !== S2) begin errors++; $display("FAIL d24_hex1 got %b exp %b", hex1, S2); end
    checks++; if (hex0 !== S4) begin errors++; $display("FAIL d24_hex0 got %b exp %b", hex0, S4); end
    checks++; if (buzzer !== 1'b0 || expired !== 1'b0) begin errors++; $display("FAIL d24_flags got %b%b exp 00", buzzer, expired); end
    count = 5'd7; tick();
    checks++; if (hex0 !== S4) begin errors++; $display("FAIL latency_hex0 got %b exp %b", hex0, S4); end
    tick();
    checks++; if (hex1 !== BLK) begin errors++; $display("FAIL d7_hex1 got %b exp %b", hex1, BLK); end
    checks++; if (hex0 !== S7) begin errors++; $display("FAIL d7_hex0 got %b exp %b", hex0, S7); end
    count = 5'd31; tick(); tick();
    checks++; if (hex1 !== S3) begin errors++; $display("FAIL d31_hex1 got %b exp %b", hex1, S3); end
    checks++; if (hex0 !== S1) begin errors++; $display("FAIL d31_hex0 got %b exp %b", hex0, S1); end
    count = 5'd10; tick(); tick();
    checks++; if (hex1 !== S1 || hex0 !== S0) begin errors++; $display("FAIL d10 got %b %b exp %b %b", hex1, hex0, S1, S0); end
    count = 5'd9; tick(); tick();
    checks++; if (hex1 !== BLK) begin errors++; $display("FAIL d9_hex1 got %b exp %b", hex1, BLK); end
  endtask

  task automatic test_expiry();
    logic [6:0] exp_seg;
    count = 5'd1; tick(); tick();
    count = 5'd0; tick();
    checks++; if (hex0 !== S1 || buzzer !== 1'b0) begin errors++; $display("FAIL pre_flash got %b %b exp %b 0", hex0, buzzer, S1); end
    tick();
    for (int i = 0; i < 8; i++) begin
      exp_seg = ((i / 2) % 2 == 1) ? BLK : S0;
      checks++; if (buzzer !== 1'b1) begin errors++; $display("FAIL flash_buzzer[%0d] got %b exp 1", i, buzzer); end
      checks++; if (hex1 !== exp_seg || hex0 !== exp_seg) begin errors++; $display("FAIL flash_seg[%0d] got %b %b exp %b", i, hex1, hex0, exp_seg); end
      checks++; if (expired !== 1'b0) begin errors++; $display("FAIL flash_expired[%0d] got %b exp 0", i, expired); end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      checks++; if (buzzer !== 1'b0 || expired !== 1'b1) begin errors++; $display("FAIL done_flags[%0d] got b=%b e=%b exp b=0 e=1", i, buzzer, expired); end
      checks++; if (hex1 !== S0 || hex0 !== S0) begin errors++; $display("FAIL done_seg[%0d] got %b %b exp %b", i, hex1, hex0, S0); end
      tick();
    end
    count = 5'd24; tick(); tick();
    checks++; if (expired !== 1'b0 || hex1 !== S2 || hex0 !== S4) begin errors++; $display("FAIL done_reload got e=%b %b %b exp e=0 %b %b", expired, hex1, hex0, S2, S4); end
  endtask

  task automatic test_reload_mid_flash();
    count = 5'd0; tick(); tick();
    tick(); tick();
    checks++; if (buzzer !== 1'b1 || hex0 !== BLK) begin errors++; $display("FAIL mid_off got b=%b %b exp b=1 %b", buzzer, hex0, BLK); end
    count = 5'd30; tick();
    checks++; if (buzzer !== 1'b1) begin errors++; $display("FAIL mid_pipe_buzzer got %b exp 1", buzzer); end
    tick();
    checks++; if (buzzer !== 1'b0 || expired !== 1'b0) begin errors++; $display("FAIL mid_reload_flags got %b%b exp 00", buzzer, expired); end
    checks++; if (hex1 !== S3 || hex0 !== S0) begin errors++; $display("FAIL mid_reload_seg got %b %b exp %b %b", hex1, hex0, S3, S0); end
  endtask

  task automatic test_reset_mid_flash();
    int buzz_seen;
    count = 5'd0; tick(); tick(); tick();
    checks++; if (buzzer !== 1'b1) begin errors++; $display("FAIL rst_pre_buzzer got %b exp 1", buzzer); end
    #2 reset = 1'b1;
    #1;
    checks++; if (hex1 !== BLK || hex0 !== BLK) begin errors++; $display("FAIL async_rst_seg got %b %b exp %b", hex1, hex0, BLK); end
    checks++; if (buzzer !== 1'b0 || expired !== 1'b0) begin errors++; $display("FAIL async_rst_flags got %b%b exp 00", buzzer, expired); end
    tick(); tick();
    reset = 1'b0;
    buzz_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (buzzer !== 1'b0 || expired !== 1'b0) buzz_seen++;
    end
    checks++; if (buzz_seen != 0) begin errors++; $display("FAIL idle_zero_alarm got %0d cycles exp 0", buzz_seen); end
    checks++; if (hex0 !== S0) begin errors++; $display("FAIL idle_zero_hex0 got %b exp %b", hex0, S0); end
  endtask

  task automatic test_reload_final_toggle();
    int exp_seen;
    count = 5'd1; tick(); tick();
    count = 5'd0; tick(); tick();
    checks++; if (buzzer !== 1'b1) begin errors++; $display("FAIL final_start got %b exp 1", buzzer); end
    for (int i = 0; i < 6; i++) tick();
    count = 5'd24; tick();
    checks++; if (buzzer !== 1'b1 || hex0 !== BLK) begin errors++; $display("FAIL final_last_off got b=%b %b exp b=1 %b", buzzer, hex0, BLK); end
    tick();
    checks++; if (buzzer !== 1'b0 || expired !== 1'b0) begin errors++; $display("FAIL final_reload_flags got %b%b exp 00", buzzer, expired); end
    checks++; if (hex1 !== S2 || hex0 !== S4) begin errors++; $display("FAIL final_reload_seg got %b %b exp %b %b", hex1, hex0, S2, S4); end
    exp_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (expired !== 1'b0) exp_seen++;
    end
    checks++; if (exp_seen != 0) begin errors++; $display("FAIL final_no_done got %0d cycles exp 0", exp_seen); end
  endtask

  initial begin
    test_reset();
    test_digits();
    test_expiry();
    test_reload_mid_flash();
    test_reset_mid_flash();
    test_reload_final_toggle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
